// File: rtl/bram_block_device.sv
// bram_block_device
// -----------------
// BRAM-backed stand-in for sd_controller. It speaks the same user-side
// byte-stream handshake and pacing, but stores NUM_BLOCKS x 512-byte blocks
// in on-chip RAM instead of talking to a card. There are no SPI pins.
//
// Ports
//   clk                  system clock
//   rst_n                asynchronous active-low reset
//   ready                idle, a rd or wr request is accepted this clock
//   address[31:0]        byte address; block = address[9 +: log2(NUM_BLOCKS)]
//   rd                   read request (level, sampled only in idle)
//   dout[7:0]            read byte, valid from the byte_available rise
//   byte_available       high for the first BYTE_PERIOD/2 clocks of a read slot
//   wr                   write request (level, sampled only in idle)
//   din[7:0]             write byte, sampled on the last clock of each slot
//   ready_for_next_byte  one-clock pulse at the start of each write slot
//   blocks_read[15:0]    completed read blocks (wrapping)
//   blocks_written[15:0] completed write blocks (wrapping)
module bram_block_device #(
  parameter int NUM_BLOCKS  = 64,
  parameter int BYTE_PERIOD = 32,
  parameter int INIT_CYCLES = 1000,
  parameter int CMD_LATENCY = 64,
  parameter int BUSY_CYCLES = 256,
  parameter int GAP_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ready,
  input  logic [31:0] address,
  input  logic        rd,
  output logic [7:0]  dout,
  output logic        byte_available,
  input  logic        wr,
  input  logic [7:0]  din,
  output logic        ready_for_next_byte,
  output logic [15:0] blocks_read,
  output logic [15:0] blocks_written
);

  localparam int BLK_W  = $clog2(NUM_BLOCKS);
  localparam int ADDR_W = BLK_W + 9;
  localparam int DEPTH  = NUM_BLOCKS * 512;

  localparam logic [31:0] INIT_LAST = 32'(INIT_CYCLES - 1);
  localparam logic [31:0] CMD_LAST  = 32'(CMD_LATENCY);
  localparam logic [31:0] SLOT_LAST = 32'(BYTE_PERIOD - 1);
  localparam logic [31:0] HALF_LAST = 32'(BYTE_PERIOD / 2 - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] BUSY_LAST = 32'(BUSY_CYCLES - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RD_SETUP,
    S_RD_BYTE,
    S_RD_GAP,
    S_WR_SETUP,
    S_WR_BYTE,
    S_WR_BUSY
  } state_t;

  state_t             state_reg, state_next;
  logic [31:0]        cnt_reg, cnt_next;
  logic [BLK_W-1:0]   blk_reg, blk_next;
  logic [8:0]         byte_reg, byte_next;
  logic               ready_reg, ready_next;
  logic [7:0]         dout_reg, dout_next;
  logic               ba_reg, ba_next;
  logic               rfnb_reg, rfnb_next;
  logic [15:0]        br_reg, br_next;
  logic [15:0]        bw_reg, bw_next;

  // Storage. The RAM holds data XOR'ed with the power-up pattern
  // (block + byte) mod 256, so a zero-initialised BRAM reads back as that
  // pattern without any load sequence and reset never disturbs contents.
  logic [7:0]         mem [DEPTH];
  logic [7:0]         ram_q;
  logic [7:0]         pat_q;
  logic [7:0]         rdata;
  logic [ADDR_W-1:0]  raddr;
  logic [ADDR_W-1:0]  waddr;
  logic               mem_we;

  logic               unused_addr_bits;
  assign unused_addr_bits = ^{address[31:ADDR_W], address[8:0]};

  function automatic logic [7:0] pattern(input logic [ADDR_W-1:0] a);
    return 8'(a[ADDR_W-1:9]) + a[7:0];
  endfunction

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[waddr] <= din ^ pattern(waddr);
    end
    ram_q <= mem[raddr];
    pat_q <= pattern(raddr);
  end

  assign rdata = ram_q ^ pat_q;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    blk_next   = blk_reg;
    byte_next  = byte_reg;
    dout_next  = dout_reg;
    ba_next    = ba_reg;
    rfnb_next  = 1'b0;
    br_next    = br_reg;
    bw_next    = bw_reg;
    mem_we     = 1'b0;
    waddr      = {blk_reg, byte_reg};
    // During a read slot the RAM is always fetching the following byte.
    raddr      = {blk_reg, byte_reg + 9'd1};

    case (state_reg)
      S_INIT: begin
        if (cnt_reg == INIT_LAST) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end

      S_IDLE: begin
        // Start fetching byte 0 of the addressed block already, so even a
        // zero command latency has the first byte ready.
        raddr = {address[9 +: BLK_W], 9'd0};
        if (rd) begin
          blk_next   = address[9 +: BLK_W];
          state_next = S_RD_SETUP;
          cnt_next   = '0;
        end else if (wr) begin
          blk_next   = address[9 +: BLK_W];
          state_next = S_WR_SETUP;
          cnt_next   = '0;
        end
      end

      S_RD_SETUP: begin
        raddr = {blk_reg, 9'd0};
        if (cnt_reg == CMD_LAST) begin
          state_next = S_RD_BYTE;
          cnt_next   = '0;
          byte_next  = '0;
          dout_next  = rdata;
          ba_next    = 1'b1;
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end

      S_RD_BYTE: begin
        if (cnt_reg == HALF_LAST) begin
          ba_next = 1'b0;
        end
        if (cnt_reg == SLOT_LAST) begin
          cnt_next = '0;
          if (byte_reg == 9'd511) begin
            state_next = S_RD_GAP;
            br_next    = br_reg + 16'd1;
          end else begin
            byte_next = byte_reg + 9'd1;
            dout_next = rdata;
            ba_next   = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end

      S_RD_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end

      S_WR_SETUP: begin
        if (cnt_reg == CMD_LAST) begin
          state_next = S_WR_BYTE;
          cnt_next   = '0;
          byte_next  = '0;
          rfnb_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end

      S_WR_BYTE: begin
        if (cnt_reg == SLOT_LAST) begin
          // Last clock of the slot: commit din for the current byte.
          mem_we   = 1'b1;
          cnt_next = '0;
          if (byte_reg == 9'd511) begin
            state_next = S_WR_BUSY;
          end else begin
            byte_next = byte_reg + 9'd1;
            rfnb_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end

      S_WR_BUSY: begin
        if (cnt_reg == BUSY_LAST) begin
          state_next = S_IDLE;
          cnt_next   = '0;
          bw_next    = bw_reg + 16'd1;
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end

      default: begin
        state_next = S_INIT;
        cnt_next   = '0;
      end
    endcase

    ready_next = (state_next == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_INIT;
      cnt_reg   <= '0;
      blk_reg   <= '0;
      byte_reg  <= '0;
      ready_reg <= 1'b0;
      dout_reg  <= 8'h00;
      ba_reg    <= 1'b0;
      rfnb_reg  <= 1'b0;
      br_reg    <= '0;
      bw_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      blk_reg   <= blk_next;
      byte_reg  <= byte_next;
      ready_reg <= ready_next;
      dout_reg  <= dout_next;
      ba_reg    <= ba_next;
      rfnb_reg  <= rfnb_next;
      br_reg    <= br_next;
      bw_reg    <= bw_next;
    end
  end

  assign ready               = ready_reg;
  assign dout                = dout_reg;
  assign byte_available      = ba_reg;
  assign ready_for_next_byte = rfnb_reg;
  assign blocks_read         = br_reg;
  assign blocks_written      = bw_reg;

endmodule

// File: tb/tb_bram_block_device.sv
// Testbench for bram_block_device: drives block reads and writes through the
// byte-stream handshake and checks data and pacing against a byte-array
// model of the storage plus timing figures derived from the parameters.
module tb_bram_block_device;

  localparam int NB = 64;
  localparam int BP = 4;
  localparam int CL = 8;
  localparam int IC = 20;
  localparam int BC = 16;
  localparam int GC = 4;
  localparam int RD_DONE = 1 + CL + 512 * BP + GC;
  localparam int WR_DONE = 1 + CL + 512 * BP + BC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ready;
  logic [31:0] address = '0;
  logic        rd = 1'b0;
  logic [7:0]  dout;
  logic        byte_available;
  logic        wr = 1'b0;
  logic [7:0]  din = '0;
  logic        ready_for_next_byte;
  logic [15:0] blocks_read;
  logic [15:0] blocks_written;

  always #5 clk = ~clk;

  bram_block_device #(
    .NUM_BLOCKS (NB),
    .BYTE_PERIOD(BP),
    .INIT_CYCLES(IC),
    .CMD_LATENCY(CL),
    .BUSY_CYCLES(BC),
    .GAP_CYCLES (GC)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ready              (ready),
    .address            (address),
    .rd                 (rd),
    .dout               (dout),
    .byte_available     (byte_available),
    .wr                 (wr),
    .din                (din),
    .ready_for_next_byte(ready_for_next_byte),
    .blocks_read        (blocks_read),
    .blocks_written     (blocks_written)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: plain byte array plus completion counters.
  logic [7:0] model_mem [NB*512];
  int         model_rd = 0;
  int         model_wr = 0;

  logic [7:0] rd_buf [512];
  logic [7:0] wr_buf [512];

  int obs_rises, obs_first, obs_gap_bad, obs_ba_high, obs_ready_clk;
  int obs_rfnb, obs_hold_bad, obs_ready_after_accept, obs_pulses;
  int init_first_ready, init_other_bad;

  function automatic int blk_of(input logic [31:0] a);
    return int'((a >> 9) % NB);
  endfunction

  function automatic int read_errors(input int blk);
    int e = 0;
    for (int n = 0; n < 512; n++) begin
      if (rd_buf[n] !== model_mem[blk*512 + n]) e++;
    end
    return e;
  endfunction

  task automatic model_init();
    for (int b = 0; b < NB; b++) begin
      for (int n = 0; n < 512; n++) begin
        model_mem[b*512 + n] = 8'((b + n) % 256);
      end
    end
  endtask

  // Releases reset at a falling edge and counts rising edges until ready.
  task automatic release_and_wait();
    init_first_ready = 0;
    init_other_bad   = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (byte_available !== 1'b0 || ready_for_next_byte !== 1'b0 || dout !== 8'h00 ||
          blocks_read !== 16'd0 || blocks_written !== 16'd0) init_other_bad++;
      if (ready === 1'b1) begin
        init_first_ready = k;
        break;
      end
    end
  endtask

  // One read block; rd (and wr when with_wr) dropped at rise number drop_after.
  task automatic run_read(input logic [31:0] addr, input bit with_wr, input int drop_after);
    int   last;
    logic prev_ba;
    logic [7:0] prev_dout;
    last = 0;
    obs_rises = 0; obs_first = 0; obs_gap_bad = 0; obs_ba_high = 0;
    obs_ready_clk = 0; obs_rfnb = 0; obs_hold_bad = 0;
    address = addr;
    rd = 1'b1;
    wr = with_wr;
    @(posedge clk); #1;
    obs_ready_after_accept = int'(ready);
    prev_ba   = byte_available;
    prev_dout = dout;
    for (int k = 1; k <= 5000; k++) begin
      @(posedge clk); #1;
      if (byte_available === 1'b1 && prev_ba === 1'b0) begin
        if (obs_rises == 0) obs_first = k;
        else if (k - last != BP) obs_gap_bad++;
        last = k;
        if (obs_rises < 512) rd_buf[obs_rises] = dout;
        obs_rises++;
        if (obs_rises == drop_after) begin
          rd = 1'b0;
          wr = 1'b0;
        end
      end else if (dout !== prev_dout) begin
        obs_hold_bad++;
      end
      if (byte_available === 1'b1) obs_ba_high++;
      if (ready_for_next_byte === 1'b1) obs_rfnb++;
      prev_ba   = byte_available;
      prev_dout = dout;
      if (ready === 1'b1) begin
        obs_ready_clk = k;
        break;
      end
    end
    rd = 1'b0;
    wr = 1'b0;
    $display("rd  addr=%08h blk=%0d rises=%0d first=%0d done=%0d", addr, blk_of(addr),
             obs_rises, obs_first, obs_ready_clk);
  endtask

  // One write block from wr_buf; when abort_after>0, reset is asserted one
  // clock after pulse number abort_after.
  task automatic run_write(input logic [31:0] addr, input int abort_after);
    int last;
    last = 0;
    obs_pulses = 0; obs_first = 0; obs_gap_bad = 0; obs_ready_clk = 0; obs_rises = 0;
    address = addr;
    wr = 1'b1;
    rd = 1'b0;
    @(posedge clk); #1;
    obs_ready_after_accept = int'(ready);
    for (int k = 1; k <= 5000; k++) begin
      @(posedge clk); #1;
      if (ready_for_next_byte === 1'b1) begin
        wr = 1'b0;
        if (obs_pulses == 0) obs_first = k;
        else if (k - last != BP) obs_gap_bad++;
        last = k;
        if (obs_pulses < 512) din = wr_buf[obs_pulses];
        obs_pulses++;
        if (abort_after != 0 && obs_pulses == abort_after) begin
          @(posedge clk); #1;
          rst_n = 1'b0;
          break;
        end
      end
      if (byte_available === 1'b1) obs_rises++;
      if (ready === 1'b1) begin
        obs_ready_clk = k;
        break;
      end
    end
    wr = 1'b0;
    $display("wr  addr=%08h blk=%0d pulses=%0d first=%0d done=%0d", addr, blk_of(addr),
             obs_pulses, obs_first, obs_ready_clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({ready, dout, byte_available, ready_for_next_byte, blocks_read, blocks_written} !== 43'd0) begin
      n_bad++;
      $display("FAIL reset_values: got ready=%b dout=%h ba=%b rfnb=%b br=%0d bw=%0d required all zero",
               ready, dout, byte_available, ready_for_next_byte, blocks_read, blocks_written);
    end
    release_and_wait();
    n_cmp++;
    if (init_first_ready != IC) begin
      n_bad++;
      $display("FAIL init_ready_clk: got %0d required %0d", init_first_ready, IC);
    end
    n_cmp++;
    if (init_other_bad != 0) begin
      n_bad++;
      $display("FAIL init_outputs_hold: got %0d deviating clocks required 0", init_other_bad);
    end
  endtask

  task automatic test_read_block3();
    run_read(32'h0000_0600, 1'b0, 512);
    model_rd++;
    n_cmp++;
    if (obs_ready_after_accept != 0) begin
      n_bad++; $display("FAIL rd_ready_fall: got ready=%0d after accept required 0", obs_ready_after_accept);
    end
    n_cmp++;
    if (obs_first != CL + 1) begin
      n_bad++; $display("FAIL rd_first_rise: got clk %0d required %0d", obs_first, CL + 1);
    end
    n_cmp++;
    if (obs_rises != 512 || obs_gap_bad != 0) begin
      n_bad++; $display("FAIL rd_rises: got %0d rises %0d bad gaps required 512 and 0", obs_rises, obs_gap_bad);
    end
    n_cmp++;
    if (obs_ba_high != 512 * BP / 2 || obs_hold_bad != 0) begin
      n_bad++; $display("FAIL rd_ba_width: got %0d high clocks %0d dout changes required %0d and 0",
                        obs_ba_high, obs_hold_bad, 512 * BP / 2);
    end
    n_cmp++;
    if (read_errors(3) != 0) begin
      n_bad++; $display("FAIL rd_blk3_data: got %0d wrong bytes (byte0=%h) required 0", read_errors(3), rd_buf[0]);
    end
    n_cmp++;
    if (obs_ready_clk != RD_DONE) begin
      n_bad++; $display("FAIL rd_done_clk: got %0d required %0d", obs_ready_clk, RD_DONE);
    end
    n_cmp++;
    if (obs_ready_clk - (obs_first + 512 * BP) != GC) begin
      n_bad++; $display("FAIL rd_gap: got %0d required %0d", obs_ready_clk - (obs_first + 512 * BP), GC);
    end
    n_cmp++;
    if (blocks_read !== 16'(model_rd)) begin
      n_bad++; $display("FAIL rd_count: got %0d required %0d", blocks_read, model_rd);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] a;
    for (int n = 0; n < 512; n++) wr_buf[n] = 8'(n) ^ 8'hA5;
    a = 32'(5 * 512) | 32'($urandom_range(0, 511));
    run_write(a, 0);
    for (int n = 0; n < 512; n++) model_mem[5*512 + n] = wr_buf[n];
    model_wr++;
    n_cmp++;
    if (obs_first != CL + 1 || obs_pulses != 512 || obs_gap_bad != 0) begin
      n_bad++; $display("FAIL wr_pulses: got first=%0d count=%0d badgaps=%0d required %0d,512,0",
                        obs_first, obs_pulses, obs_gap_bad, CL + 1);
    end
    n_cmp++;
    if (obs_ready_clk != WR_DONE || obs_rises != 0) begin
      n_bad++; $display("FAIL wr_done_clk: got %0d (ba clocks %0d) required %0d (0)", obs_ready_clk, obs_rises, WR_DONE);
    end
    n_cmp++;
    if (blocks_written !== 16'(model_wr)) begin
      n_bad++; $display("FAIL wr_count: got %0d required %0d", blocks_written, model_wr);
    end
    run_read(32'h0000_0A00, 1'b0, 512);
    model_rd++;
    n_cmp++;
    if (read_errors(5) != 0) begin
      n_bad++; $display("FAIL wr_readback: got %0d wrong bytes required 0", read_errors(5));
    end
  endtask

  task automatic test_rd_wr_priority();
    run_read(32'h0000_0A00 | 32'($urandom_range(0, 511)), 1'b1, 512);
    model_rd++;
    n_cmp++;
    if (obs_rfnb != 0 || obs_rises != 512) begin
      n_bad++; $display("FAIL prio_read_runs: got rfnb=%0d rises=%0d required 0 and 512", obs_rfnb, obs_rises);
    end
    n_cmp++;
    if (read_errors(5) != 0 || blocks_written !== 16'(model_wr)) begin
      n_bad++; $display("FAIL prio_data: got %0d wrong bytes bw=%0d required 0 and %0d",
                        read_errors(5), blocks_written, model_wr);
    end
    run_read(32'h0000_0A00, 1'b0, 512);
    model_rd++;
    n_cmp++;
    if (read_errors(5) != 0) begin
      n_bad++; $display("FAIL prio_unchanged: got %0d wrong bytes required 0", read_errors(5));
    end
  endtask

  task automatic test_drop_and_wrap();
    run_read(32'(7 * 512) | 32'($urandom_range(0, 511)), 1'b0, 10);
    model_rd++;
    n_cmp++;
    if (obs_rises != 512 || obs_ready_clk != RD_DONE || read_errors(7) != 0) begin
      n_bad++; $display("FAIL drop_full_block: got rises=%0d done=%0d bad=%0d required 512,%0d,0",
                        obs_rises, obs_ready_clk, read_errors(7), RD_DONE);
    end
    run_read(32'h0001_0200, 1'b0, 512);
    model_rd++;
    n_cmp++;
    if (read_errors(1) != 0) begin
      n_bad++; $display("FAIL wrap_blk1: got %0d wrong bytes (byte0=%h) required 0", read_errors(1), rd_buf[0]);
    end
    run_read(32'h0000_0A37, 1'b0, 512);
    model_rd++;
    n_cmp++;
    if (read_errors(5) != 0) begin
      n_bad++; $display("FAIL lowbits_blk5: got %0d wrong bytes required 0", read_errors(5));
    end
    n_cmp++;
    if (blocks_read !== 16'(model_rd)) begin
      n_bad++; $display("FAIL drop_count: got %0d required %0d", blocks_read, model_rd);
    end
  endtask

  task automatic test_reset_mid_write();
    for (int n = 0; n < 512; n++) wr_buf[n] = 8'($urandom);
    run_write(32'(9 * 512), 100);
    for (int n = 0; n < 99; n++) model_mem[9*512 + n] = wr_buf[n];
    model_rd = 0;
    model_wr = 0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({ready, byte_available, ready_for_next_byte, blocks_written} !== 19'd0) begin
      n_bad++; $display("FAIL abort_reset_outputs: got ready=%b ba=%b rfnb=%b bw=%0d required all zero",
                        ready, byte_available, ready_for_next_byte, blocks_written);
    end
    release_and_wait();
    n_cmp++;
    if (init_first_ready != IC || init_other_bad != 0) begin
      n_bad++; $display("FAIL abort_init: got ready clk %0d deviations %0d required %0d and 0",
                        init_first_ready, init_other_bad, IC);
    end
    run_read(32'(9 * 512), 1'b0, 512);
    model_rd++;
    n_cmp++;
    if (read_errors(9) != 0) begin
      n_bad++; $display("FAIL abort_contents: got %0d wrong bytes (b98=%h b99=%h) required 0",
                        read_errors(9), rd_buf[98], rd_buf[99]);
    end
    n_cmp++;
    if (blocks_written !== 16'(model_wr) || blocks_read !== 16'(model_rd)) begin
      n_bad++; $display("FAIL abort_counts: got bw=%0d br=%0d required %0d and %0d",
                        blocks_written, blocks_read, model_wr, model_rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int b;
    for (int t = 0; t < 6; t++) begin
      a = $urandom;
      b = blk_of(a);
      if ($urandom_range(0, 1) == 1) begin
        for (int n = 0; n < 512; n++) wr_buf[n] = 8'($urandom);
        run_write(a, 0);
        for (int n = 0; n < 512; n++) model_mem[b*512 + n] = wr_buf[n];
        model_wr++;
        n_cmp++;
        if (obs_ready_clk != WR_DONE || blocks_written !== 16'(model_wr)) begin
          n_bad++; $display("FAIL rand_write_%0d: got done=%0d bw=%0d required %0d and %0d",
                            t, obs_ready_clk, blocks_written, WR_DONE, model_wr);
        end
        // Read back through an alias differing only in ignored high bits.
        a = a + 32'(NB * 512) * 32'($urandom_range(1, 100));
      end
      run_read(a, 1'b0, 512);
      model_rd++;
      n_cmp++;
      if (read_errors(b) != 0 || blocks_read !== 16'(model_rd)) begin
        n_bad++; $display("FAIL rand_read_%0d: got %0d wrong bytes br=%0d required 0 and %0d",
                          t, read_errors(b), blocks_read, model_rd);
      end
    end
  endtask

  initial begin
    model_init();
    test_reset();
    test_read_block3();
    test_write_read();
    test_rd_wr_priority();
    test_drop_and_wrap();
    test_reset_mid_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
